// File: rtl/portgroup_pkg.sv
// Shared types and helpers for the portgroup receive path.
// Holds the FSM state encoding, the status flag bundle and the parity helper.
package portgroup_pkg;

  typedef enum logic [2:0] {
    idle,
    shift,
    parity,
    commit,
    wait_end
  } rx_state_t;

  typedef struct packed {
    logic valid;
    logic ovf;
    logic perr;
    logic ferr;
  } rx_stat_t;

  localparam int max_width_c = 64;

  // Narrower words are zero-extended by the caller, which leaves the XOR unchanged.
  function automatic logic xor_reduce(input logic [max_width_c-1:0] vec);
    return ^vec;
  endfunction

endpackage

// File: rtl/portgroup_rx_if.sv
// Serial receive and register-file signal bundle for portgroup_rx.
// The master side is the serial source and the register file; the slave side is the core.
interface portgroup_rx_if #(
  parameter int width_p = 32
);

  logic               rx_frame_i;
  logic               rx_strb_i;
  logic               rx_bit_i;
  logic               regf_ctrl_ena_rval_i;
  logic               regf_rx_data0_rd_i;
  logic [width_p-1:0] regf_rx_data0_wval_o;
  logic               regf_rx_data0_wr_o;
  logic               regf_stat_valid_wval_o;
  logic               regf_stat_ovf_wval_o;
  logic               regf_stat_perr_wval_o;
  logic               regf_stat_ferr_wval_o;
  logic               regf_stat_wr_o;

  modport master (
    output rx_frame_i,
    output rx_strb_i,
    output rx_bit_i,
    output regf_ctrl_ena_rval_i,
    output regf_rx_data0_rd_i,
    input  regf_rx_data0_wval_o,
    input  regf_rx_data0_wr_o,
    input  regf_stat_valid_wval_o,
    input  regf_stat_ovf_wval_o,
    input  regf_stat_perr_wval_o,
    input  regf_stat_ferr_wval_o,
    input  regf_stat_wr_o
  );

  modport slave (
    input  rx_frame_i,
    input  rx_strb_i,
    input  rx_bit_i,
    input  regf_ctrl_ena_rval_i,
    input  regf_rx_data0_rd_i,
    output regf_rx_data0_wval_o,
    output regf_rx_data0_wr_o,
    output regf_stat_valid_wval_o,
    output regf_stat_ovf_wval_o,
    output regf_stat_perr_wval_o,
    output regf_stat_ferr_wval_o,
    output regf_stat_wr_o
  );

endinterface

// File: rtl/portgroup_rx_shift.sv
// LSB-first deserialiser: shift register, bit counter and even-parity check.
// 'last' looks ahead so the FSM can leave SHIFT on the strobe that completes the word.
module portgroup_rx_shift
  import portgroup_pkg::*;
#(
  parameter int width_p = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               shift_en,
  input  logic               bit_in,
  output logic [width_p-1:0] data,
  output logic               last,
  output logic               done,
  output logic               parity_ok
);

  localparam int cnt_w_c = $clog2(width_p + 1);

  logic [cnt_w_c-1:0] count_q;
  logic [cnt_w_c-1:0] count_base;
  logic [width_p-1:0] shreg_q;
  logic [width_p-1:0] shreg_next;

  // Clearing and shifting in the same cycle makes the new bit count as bit 0.
  assign count_base = clear ? '0 : count_q;
  assign last       = (count_base == cnt_w_c'(width_p - 1));
  assign done       = (count_q == cnt_w_c'(width_p));
  assign parity_ok  = ~(xor_reduce(max_width_c'(shreg_q)) ^ bit_in);
  assign data       = shreg_q;

  generate
    if (width_p == 1) begin : g_single
      assign shreg_next = bit_in;
    end else begin : g_multi
      assign shreg_next = {bit_in, shreg_q[width_p-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      shreg_q <= '0;
    end else if (shift_en) begin
      count_q <= count_base + cnt_w_c'(1);
      shreg_q <= shreg_next;
    end else if (clear) begin
      count_q <= '0;
    end
  end

endmodule

// File: rtl/portgroup_rx.sv
// Receive core: frames serial words, checks even parity and posts words and
// sticky status flags to the register file through core-write strobes.
module portgroup_rx
  import portgroup_pkg::*;
#(
  parameter int width_p = 32
) (
  input  logic            main_clk_i,
  input  logic            main_rst_an_i,
  portgroup_rx_if.slave   bus
);

  rx_state_t          state_q;
  rx_state_t          state_d;
  rx_stat_t           stat_q;
  rx_stat_t           stat_d;
  logic               block_q;
  logic               data_wr_q;
  logic               stat_wr_q;
  logic [width_p-1:0] wval_q;

  logic               ena;
  logic               frame;
  logic               strb;
  logic               rd;
  logic               shift_en;
  logic               shift_clear;
  logic               commit_now;
  logic               set_perr;
  logic               set_ferr;
  logic [width_p-1:0] shift_data;
  logic               shift_last;
  logic               shift_done;
  logic               shift_parity_ok;

  assign ena   = bus.regf_ctrl_ena_rval_i;
  assign frame = bus.rx_frame_i;
  assign strb  = bus.rx_strb_i;
  assign rd    = bus.regf_rx_data0_rd_i;

  assign shift_clear = (state_q != shift) && (state_q != parity);

  portgroup_rx_shift #(
    .width_p (width_p)
  ) u_shift (
    .clk       (main_clk_i),
    .rst_n     (main_rst_an_i),
    .clear     (shift_clear),
    .shift_en  (shift_en),
    .bit_in    (bus.rx_bit_i),
    .data      (shift_data),
    .last      (shift_last),
    .done      (shift_done),
    .parity_ok (shift_parity_ok)
  );

  // A frame that was high while disabled must end before a new one is accepted.
  always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
    if (!main_rst_an_i) begin
      block_q <= 1'b0;
    end else if (!frame) begin
      block_q <= 1'b0;
    end else if (!ena) begin
      block_q <= 1'b1;
    end
  end

  always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
    if (!main_rst_an_i) begin
      state_q <= idle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_en   = 1'b0;
    commit_now = 1'b0;
    set_perr   = 1'b0;
    set_ferr   = 1'b0;
    if (!ena) begin
      state_d = idle;
    end else begin
      case (state_q)
        idle: begin
          if (frame) begin
            if (block_q) begin
              state_d = wait_end;
            end else begin
              state_d = shift;
              if (strb) begin
                shift_en = 1'b1;
                if (shift_last) state_d = parity;
              end
            end
          end
        end
        shift: begin
          if (!frame) begin
            set_ferr = 1'b1;
            state_d  = idle;
          end else if (strb) begin
            shift_en = 1'b1;
            if (shift_last) state_d = parity;
          end
        end
        parity: begin
          if (!frame) begin
            set_ferr = 1'b1;
            state_d  = idle;
          end else if (strb && shift_done) begin
            if (shift_parity_ok) begin
              commit_now = 1'b1;
              state_d    = commit;
            end else begin
              set_perr = 1'b1;
              state_d  = wait_end;
            end
          end
        end
        commit:   state_d = wait_end;
        wait_end: if (!frame) state_d = idle;
        default:  state_d = idle;
      endcase
    end
  end

  // The commit decision is made on the parity strobe, so a read in that cycle
  // is the read that races the commit; it neither clears valid nor flags overflow.
  always_comb begin
    stat_d = stat_q;
    if (!ena) begin
      stat_d = '0;
    end else begin
      if (commit_now) begin
        if (stat_q.valid && !rd) stat_d.ovf = 1'b1;
        stat_d.valid = 1'b1;
      end else if (rd) begin
        stat_d.valid = 1'b0;
      end
      if (set_perr) stat_d.perr = 1'b1;
      if (set_ferr) stat_d.ferr = 1'b1;
    end
  end

  always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
    if (!main_rst_an_i) begin
      stat_q    <= '0;
      stat_wr_q <= 1'b0;
      data_wr_q <= 1'b0;
      wval_q    <= '0;
    end else begin
      stat_q    <= stat_d;
      stat_wr_q <= (stat_d != stat_q);
      data_wr_q <= commit_now;
      if (commit_now) wval_q <= shift_data;
    end
  end

  assign bus.regf_rx_data0_wval_o   = wval_q;
  assign bus.regf_rx_data0_wr_o     = data_wr_q;
  assign bus.regf_stat_valid_wval_o = stat_q.valid;
  assign bus.regf_stat_ovf_wval_o   = stat_q.ovf;
  assign bus.regf_stat_perr_wval_o  = stat_q.perr;
  assign bus.regf_stat_ferr_wval_o  = stat_q.ferr;
  assign bus.regf_stat_wr_o         = stat_wr_q;

endmodule

// File: doc/portgroup_rx.md
Name: portgroup_rx

Overview:
- Receive-direction counterpart of the portgroup transmit core.
- Deserialises an LSB-first, bit-serial, framed word with an even-parity bit.
- Writes each good word into the register file via the core-write port of rx_data0.
- Maintains receive status flags (valid, overflow, parity error, framing error) in the register file. Gated by ctrl.ena.

Parameters:
- width_p, 32, data word width in bits (legal range 1..64).

Ports:
- main_clk_i  input  1  clock
- main_rst_an_i  input  1  async reset (low-active)
- rx_frame_i  input  1  frame active, high for the whole transfer
- rx_strb_i  input  1  bit-valid strobe, one clock per bit
- rx_bit_i  input  1  serial data, sampled when rx_strb_i=1
- regf_ctrl_ena_rval_i  input  1  core read value of ctrl.ena
- regf_rx_data0_rd_i  input  1  bus-read strobe of rx_data0 (one cycle)
- regf_rx_data0_wval_o  output  width_p  core write value
- regf_rx_data0_wr_o  output  1  core write strobe
- regf_stat_valid_wval_o  output  1  word available
- regf_stat_ovf_wval_o  output  1  sticky overflow
- regf_stat_perr_wval_o  output  1  sticky parity error
- regf_stat_ferr_wval_o  output  1  sticky framing error
- regf_stat_wr_o  output  1  core write strobe for all stat fields

Behaviour:
- Interface: one clock (main_clk_i); reset is asynchronous and active-low (main_rst_an_i).
- Reset values: all outputs 0; FSM in IDLE; shift register and bit counter 0.
- All outputs are registered.
- FSM states and transitions:
  - IDLE: rx_frame_i=1 and ena=1 -> SHIFT. Bit counter cleared. A strobe in the same cycle is sampled as bit 0.
  - SHIFT: each strobe shifts rx_bit_i into MSB and shifts right (LSB first); counter +1. When the counter reaches width_p -> PARITY.
  - PARITY: the next strobe samples the parity bit. Check: XOR of data and parity must be 0 (even). Pass -> COMMIT. Fail -> set perr -> WAIT_END.
  - COMMIT: lasts exactly one cycle. Then -> WAIT_END.
  - WAIT_END: ignore strobes until rx_frame_i=0 -> IDLE.
- Commit timing:
  - Parity strobe in cycle N gives regf_rx_data0_wr_o=1 in cycle N+1 for exactly 1 cycle. wval holds the word from then on.
  - stat_valid is set in the same cycle.
- Framing error:
  - rx_frame_i=0 while in SHIFT or PARITY -> set ferr, discard the word, no data write, -> IDLE.
  - A frame shorter than width_p+1 strobes is a framing error.
- Overflow:
  - A commit while valid=1 and no rd in that cycle -> set ovf.
  - Data is still overwritten with the new word; valid stays 1.
- Read:
  - regf_rx_data0_rd_i=1 clears valid.
  - rd and commit in the same cycle: valid stays 1, ovf unchanged.
- Sticky flags: ovf, perr and ferr clear only when ena=0.
- ena=0, at any time, including mid-frame:
  - FSM -> IDLE next cycle; partial word discarded.
  - valid, ovf, perr and ferr cleared.
  - data wval holds its value.
  - If the frame is still high when ena returns, wait for rx_frame_i=0 before accepting a new frame (pass through WAIT_END).
- regf_stat_wr_o: pulses 1 cycle whenever any stat wval changes. Every stat field is written together.
- Strobe with rx_frame_i=0 in IDLE: ignored.
- Bit counter width is $clog2(width_p+1). No wrap: saturation is impossible because the FSM leaves SHIFT at width_p.

Decomposition:
- Shared package portgroup_pkg:
  - FSM state enum: idle, shift, parity, commit, wait_end.
  - Status struct: valid, ovf, perr, ferr.
  - Parity function (XOR reduce).
- Optional sub-module portgroup_rx_shift: shift register, bit counter and parity accumulator, with done and parity_ok outputs.
- FSM and status logic stay in the top level.

Test Plan (width_p=8):
- ena=1; frame of bits 0xA5 LSB-first plus parity 0 -> wr_o=1 one cycle after the parity strobe, wval=0xA5, valid=1, stat_wr_o=1 in that same cycle.
- 0xA5 with parity 1 -> perr=1, no data wr_o, valid=0; strobes until frame drop ignored.
- Frame dropped after 3 strobes -> ferr=1, no data write, FSM back to IDLE; a following good 0x3C frame is written correctly.
- Two good frames 0x11 then 0x22, no read -> ovf=1, wval=0x22, valid=1. Then rd pulse -> valid=0, ovf stays 1.
- rd_i asserted in the exact commit cycle of 0x5A -> valid=1, ovf=0.
- ena dropped mid-frame after 4 bits -> all flags 0 next cycle, no write. ena raised with frame still high -> nothing captured until the frame goes low and a new frame starts.
- Async reset mid-frame -> all outputs 0 immediately.
